// File: rtl/aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule (with aes_sbox)
// Purpose  : Iterative AES-128/192/256 key expander. It produces one key word
//            per cycle through four forward S-boxes and streams round keys
//            over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; this maps 0 to 0, as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] w_inv;

    assign w_inv  = gf_inv(i_byte);
    assign o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
                  ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

module aes_key_schedule #(
    parameter int KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [KEY_BITS-1:0] key_in,
    output logic                ready_o,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [127:0]        rk_data,
    output logic [3:0]          rk_index,
    output logic                rk_last
);
    localparam int         c_NK       = KEY_BITS / 32;
    localparam int         c_NR       = c_NK + 6;
    localparam logic [2:0] c_MOD_LAST = 3'(c_NK - 1);
    localparam logic [3:0] c_NR_IDX   = 4'(c_NR);
    localparam bit         c_IS_256   = (c_NK == 8);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    // r_win[0] is w[i-Nk] and r_win[Nk-1] is w[i-1]. While i<Nk the window
    // is the key rotated by i, so r_win[0] is key word i.
    logic [31:0] r_win [c_NK];
    logic [2:0]  r_mod;
    logic        r_pre;
    logic [1:0]  r_grp;
    logic [7:0]  r_rcon;
    logic [95:0] r_asm;
    logic [3:0]  r_round;

    logic [31:0] w_prev;
    logic [31:0] w_oldest;
    logic [31:0] w_sub_in;
    logic [31:0] w_sub_out;
    logic [31:0] w_new;
    logic        w_rot_step;
    logic        w_sub_step;

    assign w_prev     = r_win[c_NK-1];
    assign w_oldest   = r_win[0];
    assign w_rot_step = !r_pre && (r_mod == 3'd0);
    assign w_sub_step = !r_pre && c_IS_256 && (r_mod == 3'd4);
    assign w_sub_in   = w_rot_step ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    generate
        for (genvar b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_sub_in[8*b +: 8]),
                .o_byte (w_sub_out[8*b +: 8])
            );
        end
    endgenerate

    always_comb begin
        w_new = w_oldest;
        if (w_rot_step) begin
            w_new = w_oldest ^ w_sub_out ^ {r_rcon, 24'h000000};
        end else if (w_sub_step) begin
            w_new = w_oldest ^ w_sub_out;
        end else if (!r_pre) begin
            w_new = w_oldest ^ w_prev;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready_o      = 1'b0;
        rk_valid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (start) w_state_next = S_GEN;
            end
            S_GEN: begin
                if (r_grp == 2'd3) w_state_next = S_HOLD;
            end
            S_HOLD: begin
                rk_valid = 1'b1;
                if (rk_ready) w_state_next = rk_last ? S_IDLE : S_GEN;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_NK; k++) r_win[k] <= '0;
            r_mod    <= 3'd0;
            r_pre    <= 1'b1;
            r_grp    <= 2'd0;
            r_rcon   <= 8'h01;
            r_asm    <= '0;
            r_round  <= 4'd0;
            rk_data  <= '0;
            rk_index <= 4'd0;
            rk_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < c_NK; k++) begin
                            r_win[k] <= key_in[KEY_BITS-1-32*k -: 32];
                        end
                        r_mod   <= 3'd0;
                        r_pre   <= 1'b1;
                        r_grp   <= 2'd0;
                        r_rcon  <= 8'h01;
                        r_round <= 4'd0;
                    end
                end
                S_GEN: begin
                    for (int k = 0; k < c_NK - 1; k++) r_win[k] <= r_win[k+1];
                    r_win[c_NK-1] <= w_new;
                    r_asm         <= {r_asm[63:0], w_new};
                    r_grp         <= r_grp + 2'd1;
                    if (r_mod == c_MOD_LAST) begin
                        r_mod <= 3'd0;
                        r_pre <= 1'b0;
                    end else begin
                        r_mod <= r_mod + 3'd1;
                    end
                    if (w_rot_step) begin
                        r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
                    end
                    if (r_grp == 2'd3) begin
                        rk_data  <= {r_asm, w_new};
                        rk_index <= r_round;
                        rk_last  <= (r_round == c_NR_IDX);
                    end
                end
                S_HOLD: begin
                    if (rk_ready) r_round <= r_round + 4'd1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule
// Purpose  : Self-checking bench for aes_key_schedule at all three key sizes.
//            It compares the DUT output against a table-driven FIPS-197
//            expansion model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         rk_ready = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic [255:0] key_drv = '0;

    logic         ready_a, valid_a, last_a, ready_b, valid_b, last_b, ready_c, valid_c, last_c;
    logic [127:0] data_a, data_b, data_c;
    logic [3:0]   idx_a, idx_b, idx_c;
    logic         obs_ready, obs_valid, obs_last;
    logic [127:0] obs_data;
    logic [3:0]   obs_index;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] exp_rk [15];
    logic [127:0] got_data [16];
    logic [3:0]   got_idx [16];
    logic         got_last [16];
    int           got_cyc [16];
    logic [127:0] ref_seq [16];
    int           n_hs, n_unstable;
    bit           timed_out, ready_after;

    always #5 clk = ~clk;

    aes_key_schedule #(.KEY_BITS(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd0), .key_in(key_drv[255:128]),
        .ready_o(ready_a), .rk_valid(valid_a), .rk_ready(rk_ready), .rk_data(data_a),
        .rk_index(idx_a), .rk_last(last_a)
    );
    aes_key_schedule #(.KEY_BITS(192)) u_dut192 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd1), .key_in(key_drv[255:64]),
        .ready_o(ready_b), .rk_valid(valid_b), .rk_ready(rk_ready), .rk_data(data_b),
        .rk_index(idx_b), .rk_last(last_b)
    );
    aes_key_schedule #(.KEY_BITS(256)) u_dut256 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 2'd2), .key_in(key_drv),
        .ready_o(ready_c), .rk_valid(valid_c), .rk_ready(rk_ready), .rk_data(data_c),
        .rk_index(idx_c), .rk_last(last_c)
    );

    always_comb begin
        obs_ready = ready_a; obs_valid = valid_a; obs_data = data_a;
        obs_index = idx_a;   obs_last = last_a;
        if (sel == 2'd1) begin
            obs_ready = ready_b; obs_valid = valid_b; obs_data = data_b;
            obs_index = idx_b;   obs_last = last_b;
        end else if (sel == 2'd2) begin
            obs_ready = ready_c; obs_valid = valid_c; obs_data = data_c;
            obs_index = idx_c;   obs_last = last_c;
        end
    end

    // S-box table from the generator-3 walk over GF(2^8).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_tab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_tab[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
    endfunction

    task automatic compute_model(input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon_tab [10];
        int nr;
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [1:0] sel_of(input int nk);
        return (nk == 4) ? 2'd0 : (nk == 6) ? 2'd1 : 2'd2;
    endfunction

    // Starts one expansion (entered and left on a negedge) and captures the stream.
    task automatic run_expansion(input int nk, input logic [255:0] key, input bit stall,
                                 input bit poke, input bit start_at_last);
        int k;
        bit done, prev_hold, rdy;
        logic [127:0] prev_data;
        logic [3:0] prev_idx;
        logic prev_last;
        for (int r = 0; r < 16; r++) begin
            got_data[r] = 'x; got_idx[r] = 'x; got_last[r] = 1'bx; got_cyc[r] = -1;
        end
        n_hs = 0; n_unstable = 0; timed_out = 0; ready_after = 0;
        sel = sel_of(nk); key_drv = key; rk_ready = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; k = 0; done = 0; prev_hold = 0;
        prev_data = '0; prev_idx = '0; prev_last = 1'b0;
        while (!done && k < 2000) begin
            if (prev_hold && (obs_valid !== 1'b1 || obs_data !== prev_data ||
                              obs_index !== prev_idx || obs_last !== prev_last)) n_unstable++;
            if (poke) begin
                start = (k == 2 || k == 4);
                key_drv = ~key;
            end
            rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = rdy;
            if (obs_valid === 1'b1 && rdy) begin
                if (n_hs < 16) begin
                    got_data[n_hs] = obs_data; got_idx[n_hs] = obs_index;
                    got_last[n_hs] = obs_last; got_cyc[n_hs] = k;
                end
                n_hs++;
                if (obs_last === 1'b1) begin
                    done = 1;
                    if (start_at_last) start = 1'b1;
                end
            end
            prev_hold = (obs_valid === 1'b1) && !rdy;
            prev_data = obs_data; prev_idx = obs_index; prev_last = obs_last;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        timed_out = !done;
        ready_after = (obs_ready === 1'b1);
        start = 1'b0; rk_ready = 1'b0; key_drv = key;
    endtask

    task automatic test_expansion(input int nk, input logic [255:0] key, input bit stall,
                                  input bit poke, input bit start_at_last, input string name);
        int nr;
        nr = nk + 6;
        compute_model(nk, key);
        run_expansion(nk, key, stall, poke, start_at_last);
        n_checks++;
        if (timed_out) begin
            n_fail++; $display("FAIL %s timeout: rk_last never seen, handshakes=%0d", name, n_hs);
        end
        n_checks++;
        if (n_hs !== nr + 1) begin
            n_fail++; $display("FAIL %s handshakes: got %0d expected %0d", name, n_hs, nr + 1);
        end
        for (int r = 0; r <= nr; r++) begin
            n_checks++;
            if (got_data[r] !== exp_rk[r]) begin
                n_fail++; $display("FAIL %s rk%0d data: got %h expected %h", name, r, got_data[r], exp_rk[r]);
            end
            n_checks++;
            if (got_idx[r] !== 4'(r) || got_last[r] !== (r == nr)) begin
                n_fail++; $display("FAIL %s rk%0d index/last: got %0d/%b expected %0d/%b",
                                   name, r, got_idx[r], got_last[r], r, (r == nr));
            end
            if (!stall) begin
                n_checks++;
                if (got_cyc[r] !== 5 * r + 4) begin
                    n_fail++; $display("FAIL %s rk%0d timing: valid after edge %0d expected %0d",
                                       name, r, got_cyc[r], 5 * r + 4);
                end
            end
        end
        n_checks++;
        if (n_unstable !== 0) begin
            n_fail++; $display("FAIL %s stall stability: got %0d changes expected 0", name, n_unstable);
        end
        n_checks++;
        if (!ready_after) begin
            n_fail++; $display("FAIL %s ready_o after last handshake: got 0 expected 1", name);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            n_checks++;
            if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_data !== 128'h0 ||
                obs_index !== 4'h0 || obs_last !== 1'b0) begin
                n_fail++; $display("FAIL reset dut%0d: got ready=%b valid=%b data=%h idx=%0d last=%b expected 1 0 0 0 0",
                                   s, obs_ready, obs_valid, obs_data, obs_index, obs_last);
            end
        end
        sel = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_known_vectors();
        test_expansion(4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 0, 0, 0, "aes128");
        n_checks++;
        if (got_data[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            n_fail++; $display("FAIL aes128 rk0 vector: got %h expected key", got_data[0]);
        end
        n_checks++;
        if (got_data[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            n_fail++; $display("FAIL aes128 rk1 vector: got %h expected a0fafe1788542cb123a339392a6c7605", got_data[1]);
        end
        n_checks++;
        if (got_data[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || got_last[10] !== 1'b1 || got_cyc[10] !== 54) begin
            n_fail++; $display("FAIL aes128 rk10 vector: got %h last=%b edge=%0d expected d014f9a8c9ee2589e13f0cc8b6630ca6 1 54",
                               got_data[10], got_last[10], got_cyc[10]);
        end
        test_expansion(6, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 0, 0, 0, "aes192");
        n_checks++;
        if (got_data[12] !== 128'he98ba06f448c773c8ecc720401002202 || got_idx[12] !== 4'd12 ||
            got_last[12] !== 1'b1 || got_cyc[12] !== 64) begin
            n_fail++; $display("FAIL aes192 rk12 vector: got %h idx=%0d last=%b edge=%0d expected e98ba06f448c773c8ecc720401002202 12 1 64",
                               got_data[12], got_idx[12], got_last[12], got_cyc[12]);
        end
        test_expansion(8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0, 0, 0, "aes256");
        n_checks++;
        if (got_data[1] !== 128'h1f352c073b6108d72d9810a30914dff4) begin
            n_fail++; $display("FAIL aes256 rk1 vector: got %h expected 1f352c073b6108d72d9810a30914dff4", got_data[1]);
        end
        n_checks++;
        if (got_data[14] !== 128'hfe4890d1e6188d0b046df344706c631e || got_cyc[14] !== 74) begin
            n_fail++; $display("FAIL aes256 rk14 vector: got %h edge=%0d expected fe4890d1e6188d0b046df344706c631e 74",
                               got_data[14], got_cyc[14]);
        end
    endtask

    task automatic test_random_stall();
        logic [255:0] k;
        test_expansion(4, {128'h0f1571c947d9e8590cb7add6af7f6798, 128'h0}, 0, 0, 0, "stall_ref");
        for (int r = 0; r < 16; r++) ref_seq[r] = got_data[r];
        test_expansion(4, {128'h0f1571c947d9e8590cb7add6af7f6798, 128'h0}, 1, 0, 0, "stall128");
        for (int r = 0; r <= 10; r++) begin
            n_checks++;
            if (got_data[r] !== ref_seq[r]) begin
                n_fail++; $display("FAIL stall vs unstalled rk%0d: got %h expected %h", r, got_data[r], ref_seq[r]);
            end
        end
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        test_expansion(6, k, 1, 0, 0, "stall192_rand");
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        test_expansion(8, k, 1, 0, 0, "stall256_rand");
    endtask

    task automatic test_start_ignored();
        logic [255:0] k;
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        test_expansion(4, k, 0, 1, 0, "start_ignored128");
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        test_expansion(8, k, 0, 1, 0, "start_ignored256");
    endtask

    task automatic test_back_to_back();
        logic [255:0] ka, kb;
        ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        test_expansion(4, ka, 0, 0, 1, "b2b_first");
        test_expansion(4, kb, 0, 0, 0, "b2b_second");
        test_expansion(6, ka, 1, 0, 1, "b2b192_first");
        test_expansion(6, kb, 0, 0, 0, "b2b192_second");
    endtask

    task automatic test_reset_abort();
        logic [255:0] k;
        int bad;
        k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        sel = 2'd0; key_drv = k; rk_ready = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_index !== 4'd4) begin
            n_fail++; $display("FAIL abort pre-reset: got valid=%b idx=%0d expected 0 4", obs_valid, obs_index);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_ready !== 1'b1 || obs_valid !== 1'b0 || obs_data !== 128'h0 ||
            obs_index !== 4'h0 || obs_last !== 1'b0) begin
            n_fail++; $display("FAIL abort async reset: got ready=%b valid=%b data=%h idx=%0d last=%b expected 1 0 0 0 0",
                               obs_ready, obs_valid, obs_data, obs_index, obs_last);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) bad++;
        end
        rk_ready = 1'b0;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL abort after release: got %0d busy/valid cycles expected 0", bad);
        end
        test_expansion(4, k, 0, 0, 0, "after_abort");
    endtask

    initial begin
        build_sbox();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_known_vectors();
        test_random_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, parametrised AES key expander: accepts a 128/192/256-bit cipher key and streams round keys 0..Nr, one 128-bit round key per valid/ready handshake. It is the sequential successor to the fixed 128-bit combinational expansion inside the Encryption/Decryption pair. It feeds a round-iterative cipher core from a single 4-S-box datapath instead of 40 unrolled S-boxes.

## Interface
- KEY_BITS, 128, cipher key width; legal values 128, 192, 256 only, anything else is an elaboration error
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to expand key_in; accepted only when ready_o=1
- key_in  in  KEY_BITS  cipher key, word 0 in the MSBs; sampled on the accepting edge only
- ready_o  out  1  idle, able to accept start
- rk_valid  out  1  rk_data/rk_index/rk_last are valid
- rk_ready  in  1  consumer accepts the round key on clk edge when rk_valid=1
- rk_data  out  128  round key, word 4r in the MSBs
- rk_index  out  4  round number r, 0..Nr
- rk_last  out  1  high with rk_valid when rk_index=Nr

## Operation
- Derived constants: Nk=KEY_BITS/32 (4/6/8); Nr=Nk+6 (10/12/14); total words W=4(Nr+1) (44/52/60).
- States: IDLE, GEN, HOLD.
- IDLE: ready_o=1. On start, load key_in into an Nk-word window, clear word counter i=0, set rcon=8'h01, clear assembly count, go to GEN. start in GEN/HOLD is ignored, key_in not resampled.
- GEN: produce one word w[i] per cycle into a 4-word assembly register.
  - i<Nk: w[i] = key word i.
  - i>=Nk, i mod Nk=0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}; then rcon = xtime(rcon) (01,02,04,08,10,20,40,80,1b,36).
  - i>=Nk, Nk=8, i mod 8=4: w[i] = w[i-8] ^ SubWord(w[i-1]).
  - otherwise: w[i] = w[i-Nk] ^ w[i-1].
  - Window shifts by one word per generated word; modulo-Nk counter, no divider.
  - On the 4th word of a group, go to HOLD with rk_valid=1.
- HOLD: outputs stable while rk_valid=1 and rk_ready=0; no words generated.
  - On handshake, if rk_index=Nr: go to IDLE.
  - Otherwise increment rk_index and return to GEN.
- SubWord uses four instances of the team's combinational forward S-box.
- Reset values: ready_o=1, rk_valid=0, rk_data=0, rk_index=0, rk_last=0, state IDLE.
- Reset asserted mid-expansion aborts immediately; no partial round key appears after release.

## Timing
- Start accepted at edge 0. Words are generated on edges 1..4, so round key 0 is valid after edge 4.
- With rk_ready held 1:
  - Each HOLD lasts one cycle, so round key r is valid after edge 5r+4.
  - rk_last appears after edge 5Nr+4: 54/64/74 for Nk=4/6/8.
  - ready_o returns 1 the cycle after the last handshake.
- Each cycle rk_ready is low in HOLD adds exactly one cycle; no data loss or duplication.
- rk_data, rk_index and rk_last are registered and change only on entry to HOLD.
- start coincident with the final handshake is ignored because ready_o=0 that cycle; start is accepted the next cycle.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
  - rk0 equals the key.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
  - rk_last after edge 54.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk12 = e98ba06f448c773c8ecc720401002202, rk_index=12, rk_last=1.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - rk1 = 1f352c073b6108d72d9810a30914dff4.
  - rk14 = fe4890d1e6188d0b046df344706c631e.
- Random rk_ready (50%), 128-bit key 0f1571c947d9e8590cb7add6af7f6798:
  - Sequence matches the rk_ready=1 run word-for-word.
  - Outputs stable while stalled.
  - Exactly 11 handshakes.
- Pulse start with a different key during GEN and again during HOLD -> ignored, output stream unchanged. Back-to-back expansions with two keys each produce correct rk0..rkNr.
- Assert rst_n=0 during GEN of rk5 -> all outputs at reset values asynchronously. After release, a new start produces a correct full sequence from rk0.
